// File: rtl/clk_enable_gen.sv
// Multi-channel NCO clock-enable generator: each channel emits one-cycle enable
// pulses at refclk*inc/2^ACC_W; a common sync strobe phase-aligns all channels.
//
// state       | meaning
// ST_UNLOCKED | cadence recently disturbed (run low, sync, or config write); counting down
// ST_LOCKED   | LOCK_CYCLES undisturbed run cycles elapsed; cadence stable
module clk_enable_gen #(
   parameter  int CHANNELS    = 6,
   parameter  int ACC_W       = 32,
   parameter  int LOCK_CYCLES = 1024,
   localparam int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                refclk,
   input  logic                rst,
   input  logic                run,
   input  logic                sync,
   input  logic                cfg_we,
   input  logic [SEL_W-1:0]    cfg_sel,
   input  logic [ACC_W-1:0]    cfg_inc,
   input  logic [ACC_W-1:0]    cfg_phase,
   output logic [CHANNELS-1:0] ce_out,
   output logic                locked
);

   localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCK_CYCLES - 1);

   typedef enum logic {
      ST_UNLOCKED,
      ST_LOCKED
   } lock_state_t;

   logic [ACC_W-1:0]    inc_q   [CHANNELS];
   logic [ACC_W-1:0]    phase_q [CHANNELS];
   logic [ACC_W-1:0]    acc_q   [CHANNELS];
   logic [ACC_W:0]      sum     [CHANNELS];
   logic [CHANNELS-1:0] wr_hit;
   logic                disturb;

   lock_state_t         state_q, state_nxt;
   logic [CNT_W-1:0]    cnt_q, cnt_nxt;

   // Out-of-range selects match no channel, so they neither write nor disturb lock.
   always_comb begin
      wr_hit = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         wr_hit[i] = cfg_we && (cfg_sel == SEL_W'(i));
         sum[i]    = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            inc_q[i]   <= '0;
            phase_q[i] <= '0;
            acc_q[i]   <= '0;
         end
         ce_out <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (wr_hit[i]) begin
               inc_q[i]   <= cfg_inc;
               phase_q[i] <= cfg_phase;
            end
            // A phase written alongside sync is loaded straight into the accumulator.
            if (sync) begin
               acc_q[i]  <= wr_hit[i] ? cfg_phase : phase_q[i];
               ce_out[i] <= 1'b0;
            end else if (run) begin
               acc_q[i]  <= sum[i][ACC_W-1:0];
               ce_out[i] <= sum[i][ACC_W];
            end else begin
               ce_out[i] <= 1'b0;
            end
         end
      end
   end

   assign disturb = !run || sync || (|wr_hit);

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q <= ST_UNLOCKED;
         cnt_q   <= CNT_LOAD;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      if (disturb) begin
         state_nxt = ST_UNLOCKED;
         cnt_nxt   = CNT_LOAD;
      end else begin
         case (state_q)
            ST_UNLOCKED: begin
               if (cnt_q == '0) state_nxt = ST_LOCKED;
               else             cnt_nxt   = cnt_q - 1'b1;
            end
            default: state_nxt = ST_LOCKED;
         endcase
      end
   end

   assign locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen: directed vector table, hand-written cadence/lock
// sequences, and randomized traffic against an arithmetic reference model.
module tb_clk_enable_gen;

   localparam int CH = 6;
   localparam int AW = 32;
   localparam int LK = 16;
   localparam longint unsigned TWO32 = 64'h1_0000_0000;

   logic        refclk = 1'b0;
   logic        rst, run, sync, cfg_we;
   logic [2:0]  cfg_sel;
   logic [31:0] cfg_inc, cfg_phase;
   logic [5:0]  ce_out;
   logic        locked;

   int checks   = 0;
   int failures = 0;

   longint unsigned m_inc [CH];
   longint unsigned m_phase [CH];
   longint unsigned m_acc [CH];
   bit [5:0]        m_ce;
   int              m_stable;
   bit              m_locked;

   typedef struct {
      bit        rst, run, sync, we;
      bit [2:0]  sel;
      bit [31:0] inc, phase;
      bit [5:0]  ce;
      bit        lk;
   } vec_t;

   vec_t tbl [15];

   clk_enable_gen #(.CHANNELS(CH), .ACC_W(AW), .LOCK_CYCLES(LK)) dut (
      .refclk   (refclk),
      .rst      (rst),
      .run      (run),
      .sync     (sync),
      .cfg_we   (cfg_we),
      .cfg_sel  (cfg_sel),
      .cfg_inc  (cfg_inc),
      .cfg_phase(cfg_phase),
      .ce_out   (ce_out),
      .locked   (locked)
   );

   always #5 refclk = ~refclk;

   // Reference: locked means LK consecutive undisturbed cycles since the last disturbance.
   function automatic void model_edge();
      bit hit;
      bit [5:0] nce;
      longint unsigned s;
      nce = '0;
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            m_inc[i] = 0; m_phase[i] = 0; m_acc[i] = 0;
         end
         m_ce = '0; m_stable = 0; m_locked = 0;
      end else begin
         hit = cfg_we && (int'(cfg_sel) < CH);
         for (int i = 0; i < CH; i++) begin
            if (sync) begin
               m_acc[i] = (hit && int'(cfg_sel) == i) ? longint'(cfg_phase) : m_phase[i];
            end else if (run) begin
               s = m_acc[i] + m_inc[i];
               nce[i] = (s >= TWO32);
               m_acc[i] = s % TWO32;
            end
         end
         if (hit) begin
            m_inc[int'(cfg_sel)]   = longint'(cfg_inc);
            m_phase[int'(cfg_sel)] = longint'(cfg_phase);
         end
         m_ce = nce;
         if (!run || sync || hit) m_stable = 0;
         else                     m_stable++;
         m_locked = (m_stable >= LK);
      end
   endfunction

   task automatic step();
      @(posedge refclk);
      model_edge();
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1; run = 0; sync = 0; cfg_we = 0;
      step();
      rst = 0;
   endtask

   task automatic cfg(input logic [2:0] sel, input logic [31:0] inc, input logic [31:0] ph);
      cfg_we = 1; cfg_sel = sel; cfg_inc = inc; cfg_phase = ph;
      step();
      cfg_we = 0;
   endtask

   initial begin
      int first0, first2, cnt0, bad, last, cnt1, gap;
      rst = 1; run = 0; sync = 0; cfg_we = 0;
      cfg_sel = '0; cfg_inc = '0; cfg_phase = '0;

      //         rst run syn we  sel   inc           phase         ce       lk
      tbl[0]  = '{1, 0, 0, 0, 3'd0, 32'h0,        32'h0,        6'b000000, 0};
      tbl[1]  = '{0, 0, 0, 1, 3'd0, 32'h40000000, 32'h0,        6'b000000, 0};
      tbl[2]  = '{0, 0, 0, 1, 3'd2, 32'h40000000, 32'hC0000000, 6'b000000, 0};
      tbl[3]  = '{0, 0, 1, 0, 3'd0, 32'h0,        32'h0,        6'b000000, 0};
      tbl[4]  = '{0, 1, 0, 0, 3'd0, 32'h0,        32'h0,        6'b000100, 0};
      tbl[5]  = '{0, 1, 0, 0, 3'd0, 32'h0,        32'h0,        6'b000000, 0};
      tbl[6]  = '{0, 1, 0, 0, 3'd0, 32'h0,        32'h0,        6'b000000, 0};
      tbl[7]  = '{0, 1, 0, 0, 3'd0, 32'h0,        32'h0,        6'b000001, 0};
      tbl[8]  = '{0, 1, 0, 0, 3'd0, 32'h0,        32'h0,        6'b000100, 0};
      tbl[9]  = '{0, 0, 0, 0, 3'd0, 32'h0,        32'h0,        6'b000000, 0};
      tbl[10] = '{0, 1, 0, 0, 3'd0, 32'h0,        32'h0,        6'b000000, 0};
      tbl[11] = '{0, 1, 0, 1, 3'd7, 32'hFFFFFFFF, 32'h0,        6'b000000, 0};
      tbl[12] = '{0, 1, 0, 0, 3'd0, 32'h0,        32'h0,        6'b000001, 0};
      tbl[13] = '{0, 1, 1, 1, 3'd0, 32'h40000000, 32'hC0000000, 6'b000000, 0};
      tbl[14] = '{0, 1, 0, 0, 3'd0, 32'h0,        32'h0,        6'b000101, 0};

      for (int k = 0; k < 15; k++) begin
         rst = tbl[k].rst; run = tbl[k].run; sync = tbl[k].sync; cfg_we = tbl[k].we;
         cfg_sel = tbl[k].sel; cfg_inc = tbl[k].inc; cfg_phase = tbl[k].phase;
         step();
         chk($sformatf("tbl%0d_ce", k), 64'(ce_out), 64'(tbl[k].ce));
         chk($sformatf("tbl%0d_locked", k), 64'(locked), 64'(tbl[k].lk));
      end
      cfg_we = 0; sync = 0;

      // Lock: rises at edge LK, drops on a valid write, ignores out-of-range select.
      do_reset();
      run = 1;
      for (int n = 1; n <= 29; n++) begin
         step();
         chk("lock_rise", 64'(locked), 64'(n >= LK));
      end
      cfg_we = 1; cfg_sel = 3'd3; cfg_inc = '0; cfg_phase = '0;
      step();
      cfg_we = 0;
      chk("lock_drop_cfg", 64'(locked), 64'(0));
      for (int n = 1; n <= LK; n++) begin
         step();
         chk("lock_rearm", 64'(locked), 64'(n >= LK));
      end
      cfg_we = 1; cfg_sel = 3'd7; cfg_inc = 32'hFFFFFFFF;
      step();
      cfg_we = 0;
      chk("lock_bad_sel", 64'(locked), 64'(1));
      chk("bad_sel_no_pulse", 64'(ce_out), 64'(0));

      // Integer divide and phase alignment over 1000 cycles.
      do_reset();
      cfg(3'd0, 32'h40000000, 32'h0);
      cfg(3'd2, 32'h40000000, 32'hC0000000);
      sync = 1; step(); sync = 0;
      run = 1;
      first0 = 0; first2 = 0; cnt0 = 0; bad = 0;
      for (int n = 1; n <= 1000; n++) begin
         step();
         if (ce_out[0]) begin cnt0++; if (first0 == 0) first0 = n; end
         if (ce_out[2] && first2 == 0) first2 = n;
         if (ce_out[0] !== (n % 4 == 0) || ce_out[2] !== (n % 4 == 1)) bad++;
      end
      chk("div4_first", 64'(first0), 64'(4));
      chk("div4_count", 64'(cnt0), 64'(250));
      chk("align_first_ch2", 64'(first2), 64'(1));
      chk("align_pattern_errs", 64'(bad), 64'(0));

      // Fractional rate ~1/6.
      do_reset();
      cfg(3'd1, 32'h2AAAAAAB, 32'h0);
      sync = 1; step(); sync = 0;
      run = 1;
      cnt1 = 0; last = 0; bad = 0;
      for (int n = 1; n <= 6000; n++) begin
         step();
         if (ce_out[1]) begin
            cnt1++;
            gap = n - last;
            if (gap != 5 && gap != 6) bad++;
            last = n;
         end
      end
      chk("frac_count", 64'(cnt1), 64'(1000));
      chk("frac_spacing_errs", 64'(bad), 64'(0));

      // Randomized traffic against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         rst    = ($urandom_range(0, 399) == 0);
         run    = ($urandom_range(0, 29) != 0);
         sync   = ($urandom_range(0, 99) == 0);
         cfg_we = ($urandom_range(0, 39) == 0);
         cfg_sel = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0:       cfg_inc = '0;
            1:       cfg_inc = $urandom;
            2:       cfg_inc = $urandom >> 4;
            default: cfg_inc = 32'h40000000;
         endcase
         cfg_phase = $urandom;
         step();
         chk("rand_ce", 64'(ce_out), 64'(m_ce));
         chk("rand_locked", 64'(locked), 64'(m_locked));
      end

      // Reset mid-run with pulses active, then no pulses while all inc are zero.
      rst = 0; sync = 0; cfg_we = 0; run = 1;
      cfg(3'd4, 32'hF0000000, 32'h0);
      for (int n = 0; n < 8; n++) step();
      rst = 1;
      step();
      chk("rst_ce", 64'(ce_out), 64'(0));
      chk("rst_locked", 64'(locked), 64'(0));
      rst = 0;
      cnt0 = 0;
      for (int n = 0; n < 100; n++) begin
         step();
         if (ce_out != '0) cnt0++;
      end
      chk("post_rst_pulses", 64'(cnt0), 64'(0));
      chk("post_rst_model_ce", 64'(ce_out), 64'(m_ce));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clk_enable_gen.md
# clk_enable_gen

Parametrised multi-channel clock-enable generator. Each channel runs a fractional phase accumulator (NCO) off a single fast master clock and emits one-cycle clock-enable pulses at f_ref·INC/2^ACC_W. Channels are runtime-configurable and phase-aligned by a common sync strobe. The block replaces fixed-ratio derived clocks: downstream logic (CPU, video, sound) runs on `refclk` gated by its `ce_out` bit, and `locked` signals when cadence is stable.

## Interface
- `CHANNELS`, 6: number of independent enable outputs (1..16).
- `ACC_W`, 32: accumulator/increment/phase width (8..48).
- `LOCK_CYCLES`, 1024: stable cycles after run/sync/config before `locked` asserts (≥1).
- `refclk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `run`  in  1  global enable; low freezes all accumulators and forces `ce_out` to 0.
- `sync`  in  1  one-cycle strobe; reloads every accumulator with its phase register.
- `cfg_we`  in  1  config write strobe.
- `cfg_sel`  in  clog2(CHANNELS) (min 1)  target channel of write.
- `cfg_inc`  in  ACC_W  increment value written.
- `cfg_phase`  in  ACC_W  phase value written.
- `ce_out`  out  CHANNELS  registered enable pulses, bit i = channel i.
- `locked`  out  1  cadence stable indicator.

## Operation
- Per channel i: registers `inc[i]`, `phase[i]`, `acc[i]`, all ACC_W bits.
- Reset: inc, phase, acc = 0; `ce_out` = 0; `locked` = 0; lock counter = 0.
- Config: `cfg_we`=1 with `cfg_sel` < CHANNELS writes inc[sel] and phase[sel] at the edge; `cfg_sel` ≥ CHANNELS ignored entirely (no write, no lock drop). New inc takes effect on the next accumulate; new phase only at next `sync`.
- Accumulate (run=1, sync=0): sum = acc + inc (ACC_W+1 bits); acc ← sum[ACC_W-1:0]; ce_out[i] ← sum[ACC_W]. Wrap is modulo 2^ACC_W, no saturation.
- inc = 0: channel never fires. Average pulse rate is exactly inc/2^ACC_W per cycle; inter-pulse spacing is floor or ceil of 2^ACC_W/inc.
- Sync (sync=1, any run): acc[i] ← phase[i] for all i; ce_out ← 0 that cycle. If `cfg_we` in same cycle, the addressed channel loads the incoming `cfg_phase` (write-through); registers also updated.
- run=0 and sync=0: acc held; ce_out ← 0.
- Lock state machine, two states:
  - UNLOCKED: counter increments each cycle with run=1; when counter reaches LOCK_CYCLES-1 and run=1, go LOCKED, `locked` ← 1.
  - LOCKED: hold.
  - Any cycle with run=0, sync=1, or valid cfg_we (either state): counter ← 0, state UNLOCKED, `locked` ← 0 at that edge. Takes priority over increment.
- `rst` overrides everything, including in-flight writes and sync.

## Timing
- All outputs registered; no combinational input→output path.
- Sync at edge k: acc = phase at k; first possible pulse visible after edge k+1, when phase+inc carries.
- Config write at edge k: first accumulate using new inc at edge k+1.
- `locked` rises at edge LOCK_CYCLES after last disturbing cycle (run continuously high, no sync/cfg).
- Release of `rst`: outputs stay 0 until run=1; with all inc=0 no pulses ever occur.
- Critical path: one ACC_W+1 adder per channel; target ≥100 MHz at ACC_W=32.

## Test plan
- Reset: drive rst mid-run with pulses active -> next edge ce_out=0, locked=0, all acc=0; with run=1 and no writes, no pulses for 100 cycles.
- Integer divide: ch0 inc=0x40000000, phase=0, sync, run -> ce_out[0] high exactly every 4th cycle, first at 4th edge after sync; 1000 cycles yield 250 pulses.
- Fractional: ch1 inc=0x2AAAAAAB (≈1/6) over 6000 cycles -> 1000 pulses ±1, spacing only 5 or 6 (here always 6 except rounding wrap).
- Phase alignment: ch0, ch2 inc=0x40000000, phase[2]=0xC0000000, sync -> ch2 pulses at edge 1 after sync, ch0 at edge 4; offset 3 cycles held for 1000 cycles.
- Lock: LOCK_CYCLES=16, run=1 -> locked at edge 16; cfg_we to ch3 at cycle 30 -> locked 0 next edge, re-asserts 16 edges later; cfg_sel=7 (CHANNELS=6) -> no effect, locked stays 1.
- Simultaneous: cfg_we(ch0, phase=0xC0000000, inc=0x40000000) with sync same cycle -> ch0 pulses at edge 1 after; run=0 mid-stream -> ce_out 0, acc frozen, resumes same cadence on run=1.
